vga_shape_mover: RTL and testbench
==================================

// Module: vga_shape_mover
// PURPOSE
// Frame-synchronous controller that sources iShapeX/iShapeY/iShapeSize for VGA_rectangle.
// Once per N frames, during vertical sync, it resizes the square from user requests and
// moves it with edge bounce. All three outputs change atomically, so no frame tears.
// Sits between VGA_timings (oVS) and VGA_rectangle; same single pixel-clock domain.
// PARAMETERS
// WIDTH      640  visible columns
// HEIGHT     480  visible rows
// INIT_X     290  reset X (left edge), pixels
// INIT_Y     210  reset Y (top edge), pixels
// INIT_SIZE  60   reset side length, pixels
// STEP_X     2    X step per update
// STEP_Y     1    Y step per update
// SIZE_STEP  4    size change per update
// MIN_SIZE   8    lower size bound (inclusive)
// MAX_SIZE   200  upper size bound (inclusive); must be < HEIGHT
// FRAME_DIV  1    update every FRAME_DIV frames (>=1)
// PORTS
// iClk       in   1   pixel clock
// iRst       in   1   asynchronous reset, active-high
// iVS        in   1   vertical sync from VGA_timings, active-low pulse
// iEnable    in   1   level; 1 = motion on (resize works regardless)
// iSizeUp    in   1   level; grow by SIZE_STEP at next update
// iSizeDown  in   1   level; shrink by SIZE_STEP at next update
// oShapeX    out  10  square left edge
// oShapeY    out  10  square top edge
// oShapeSize out  10  square side length
// oBusy      out  1   high while the update sequence runs (non-IDLE)
// oUpdate    out  1   one-cycle pulse in the cycle the outputs commit
// BEHAVIOUR
// - Reset (async): oShapeX=INIT_X, oShapeY=INIT_Y, oShapeSize=INIT_SIZE, dirX=right,
//   dirY=down, frame count=0, state=IDLE, oBusy=0, oUpdate=0, rVSd=1.
// - Frame event: rVSd<=iVS each cycle; event = rVSd & ~iVS (falling edge, within blanking).
// - FRAME_DIV: every event increments the frame count; an event with count==FRAME_DIV-1
//   starts the sequence and clears the count.
// - FSM, one cycle per state: IDLE -> RESIZE -> CLAMP -> MOVE_X -> MOVE_Y -> COMMIT -> IDLE.
//   Work happens on shadow registers (sX, sY, sSize). Outputs load only in COMMIT.
//   Commit is registered 5 cycles after the event cycle.
// - Events while not IDLE are ignored (sequence << frame time).
// - RESIZE: up only -> sSize+=SIZE_STEP if result <= MAX_SIZE, else unchanged.
//   down only -> sSize-=SIZE_STEP if result >= MIN_SIZE, else unchanged.
//   Both or neither asserted -> unchanged.
// - CLAMP: if sX+sSize > WIDTH then sX=WIDTH-sSize. Same for Y against HEIGHT.
// - MOVE_X (skipped, i.e. no change, if iEnable=0), using 11-bit intermediates:
//   right: n=sX+STEP_X; if n+sSize >= WIDTH then sX=WIDTH-sSize and dirX=left, else sX=n.
//   left:  if sX <= STEP_X then sX=0 and dirX=right, else sX-=STEP_X.
// - MOVE_Y: identical rule on the Y axis using HEIGHT, STEP_Y and dirY (down/up).
// - Invariant after COMMIT: oShapeX+oShapeSize <= WIDTH and oShapeY+oShapeSize <= HEIGHT.
// - COMMIT: outputs <= shadows; oUpdate=1 for this cycle only.
// - Reset mid-sequence: immediate return to reset values; partial shadow work is discarded.
// STRUCTURE
// - Shared package vga_pkg: 640x480 timing localparams (WIDTH, H_FP/PW/BP, HEIGHT,
//   V_FP/PW/BP), 10-bit coordinate width, FSM state encoding.
// - One sub-module vga_axis_step: combinational (pos, size, dir, step, limit) -> (pos', dir').
//   One instance is shared by MOVE_X and MOVE_Y, with inputs muxed by state.
// TESTING
// 1 Reset held, then released -> outputs 290/210/60, oBusy=0, dirs right/down.
// 2 iEnable=1, one VS falling edge -> oUpdate 5 cycles later; X=292, Y=211, size 60.
// 3 INIT_X=578, size 60 -> X=580, dirX=left; next frame X=578. X=1 moving left -> X=0, dirX=right.
// 4 X=580, size 60, iSizeUp -> size 64, X=576. size=200 with iSizeUp -> stays 200.
//   Both requests asserted -> size unchanged.
// 5 FRAME_DIV=2 -> commits on every 2nd VS edge only. Extra VS edge while busy -> no restart.
// 6 iRst asserted in MOVE_X -> outputs return to INIT values that cycle; FSM in IDLE.

Source files
------------

// File: rtl/vga_pkg.sv
// Purpose: shared 640x480 VGA constants, coordinate width and shape-mover FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    // 640x480 @ 60 Hz timing, in pixels / lines
    localparam int WIDTH  = 640;
    localparam int H_FP   = 16;
    localparam int H_PW   = 96;
    localparam int H_BP   = 48;
    localparam int HEIGHT = 480;
    localparam int V_FP   = 10;
    localparam int V_PW   = 2;
    localparam int V_BP   = 33;

    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESIZE,
        ST_CLAMP,
        ST_MOVE_X,
        ST_MOVE_Y,
        ST_COMMIT
    } state_t;

    // DIR_INC = right / down, DIR_DEC = left / up
    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

endpackage

// File: rtl/vga_axis_step.sv
// Purpose: one-axis move with edge bounce; shared by the X and Y steps of the mover.
// Latency: purely combinational.
// Backpressure: none.
// Ports: pos/size/dir/step/limit in -> pos_next/dir_next out.
module vga_axis_step
    import vga_pkg::*;
(
    input  logic [COORD_W-1:0] pos,
    input  logic [COORD_W-1:0] size,
    input  dir_t               dir,
    input  logic [COORD_W-1:0] step,
    input  logic [COORD_W-1:0] limit,
    output logic [COORD_W-1:0] pos_next,
    output dir_t               dir_next
);

    // One extra bit so pos+step+size cannot wrap before the limit compare
    logic [COORD_W:0] adv;
    logic [COORD_W:0] far_edge;

    always_comb begin
        adv      = {1'b0, pos} + {1'b0, step};
        far_edge = adv + {1'b0, size};
        pos_next = pos;
        dir_next = dir;
        if (dir == DIR_INC) begin
            // Touching the far edge counts as a hit: park flush and reverse
            if (far_edge >= {1'b0, limit}) begin
                pos_next = limit - size;
                dir_next = DIR_DEC;
            end else begin
                pos_next = adv[COORD_W-1:0];
            end
        end else begin
            if (pos <= step) begin
                pos_next = '0;
                dir_next = DIR_INC;
            end else begin
                pos_next = pos - step;
            end
        end
    end

endmodule

// File: rtl/vga_shape_mover.sv
// Purpose: frame-synchronous resize/move of a square; outputs change atomically once per update.
// Latency: outputs commit 5 cycles after the vsync falling-edge cycle; oUpdate flags that commit.
// Backpressure: none; vsync edges arriving while a sequence runs are dropped.
// Ports: iClk/iRst, iVS (active-low vsync), iEnable/iSizeUp/iSizeDown levels,
//        oShapeX/oShapeY/oShapeSize square geometry, oBusy (sequence running), oUpdate (commit pulse).
module vga_shape_mover
    import vga_pkg::COORD_W, vga_pkg::state_t, vga_pkg::dir_t,
           vga_pkg::ST_IDLE, vga_pkg::ST_RESIZE, vga_pkg::ST_CLAMP,
           vga_pkg::ST_MOVE_X, vga_pkg::ST_MOVE_Y, vga_pkg::ST_COMMIT,
           vga_pkg::DIR_INC, vga_pkg::DIR_DEC;
#(
    parameter int WIDTH     = vga_pkg::WIDTH,
    parameter int HEIGHT    = vga_pkg::HEIGHT,
    parameter int INIT_X    = 290,
    parameter int INIT_Y    = 210,
    parameter int INIT_SIZE = 60,
    parameter int STEP_X    = 2,
    parameter int STEP_Y    = 1,
    parameter int SIZE_STEP = 4,
    parameter int MIN_SIZE  = 8,
    parameter int MAX_SIZE  = 200,
    parameter int FRAME_DIV = 1
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iVS,
    input  logic               iEnable,
    input  logic               iSizeUp,
    input  logic               iSizeDown,
    output logic [COORD_W-1:0] oShapeX,
    output logic [COORD_W-1:0] oShapeY,
    output logic [COORD_W-1:0] oShapeSize,
    output logic               oBusy,
    output logic               oUpdate
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_DIV - 1);

    localparam logic [COORD_W-1:0] WIDTH_L  = COORD_W'(WIDTH);
    localparam logic [COORD_W-1:0] HEIGHT_L = COORD_W'(HEIGHT);
    localparam logic [COORD_W-1:0] STEP_X_L = COORD_W'(STEP_X);
    localparam logic [COORD_W-1:0] STEP_Y_L = COORD_W'(STEP_Y);
    localparam logic [COORD_W-1:0] SSTEP_L  = COORD_W'(SIZE_STEP);
    localparam logic [COORD_W-1:0] INIT_X_L = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] INIT_Y_L = COORD_W'(INIT_Y);
    localparam logic [COORD_W-1:0] INIT_S_L = COORD_W'(INIT_SIZE);
    localparam logic [COORD_W:0]   WIDTH_W  = (COORD_W+1)'(WIDTH);
    localparam logic [COORD_W:0]   HEIGHT_W = (COORD_W+1)'(HEIGHT);
    localparam logic [COORD_W:0]   MAX_W    = (COORD_W+1)'(MAX_SIZE);
    // Shrinking stays legal while size >= MIN+STEP, avoiding an underflowing subtract
    localparam logic [COORD_W:0]   SHRINK_W = (COORD_W+1)'(MIN_SIZE + SIZE_STEP);

    state_t             state, state_next;
    logic               vs_d;
    logic               frame_evt;
    logic               start;
    logic [CNT_W-1:0]   frame_cnt;
    logic [COORD_W-1:0] s_x, s_y, s_size;
    dir_t               dir_x, dir_y;
    logic               grow_ok, shrink_ok, x_over, y_over;

    logic               sel_y;
    logic [COORD_W-1:0] ax_pos, ax_step, ax_limit, ax_pos_next;
    dir_t               ax_dir, ax_dir_next;

    assign frame_evt = vs_d & ~iVS;
    assign start     = (state == ST_IDLE) && frame_evt && (frame_cnt == LAST_CNT);

    assign grow_ok   = ({1'b0, s_size} + {1'b0, SSTEP_L}) <= MAX_W;
    assign shrink_ok = {1'b0, s_size} >= SHRINK_W;
    assign x_over    = ({1'b0, s_x} + {1'b0, s_size}) > WIDTH_W;
    assign y_over    = ({1'b0, s_y} + {1'b0, s_size}) > HEIGHT_W;

    // Single stepper time-shared between the two move states
    assign sel_y    = (state == ST_MOVE_Y);
    assign ax_pos   = sel_y ? s_y      : s_x;
    assign ax_dir   = sel_y ? dir_y    : dir_x;
    assign ax_step  = sel_y ? STEP_Y_L : STEP_X_L;
    assign ax_limit = sel_y ? HEIGHT_L : WIDTH_L;

    vga_axis_step u_axis_step (
        .pos      (ax_pos),
        .size     (s_size),
        .dir      (ax_dir),
        .step     (ax_step),
        .limit    (ax_limit),
        .pos_next (ax_pos_next),
        .dir_next (ax_dir_next)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        oBusy      = (state != ST_IDLE);
        oUpdate    = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_next = ST_RESIZE;
            ST_RESIZE: state_next = ST_CLAMP;
            ST_CLAMP:  state_next = ST_MOVE_X;
            ST_MOVE_X: state_next = ST_MOVE_Y;
            ST_MOVE_Y: state_next = ST_COMMIT;
            ST_COMMIT: begin
                oUpdate    = 1'b1;
                state_next = ST_IDLE;
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // Shadows always equal the outputs while idle, so each sequence starts
    // from the committed geometry without an explicit load step.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            vs_d       <= 1'b1;
            frame_cnt  <= '0;
            s_x        <= INIT_X_L;
            s_y        <= INIT_Y_L;
            s_size     <= INIT_S_L;
            dir_x      <= DIR_INC;
            dir_y      <= DIR_INC;
            oShapeX    <= INIT_X_L;
            oShapeY    <= INIT_Y_L;
            oShapeSize <= INIT_S_L;
        end else begin
            vs_d <= iVS;
            if ((state == ST_IDLE) && frame_evt) begin
                frame_cnt <= (frame_cnt == LAST_CNT) ? '0 : frame_cnt + 1'b1;
            end
            case (state)
                ST_RESIZE: begin
                    if (iSizeUp && !iSizeDown && grow_ok) begin
                        s_size <= s_size + SSTEP_L;
                    end else if (iSizeDown && !iSizeUp && shrink_ok) begin
                        s_size <= s_size - SSTEP_L;
                    end
                end
                ST_CLAMP: begin
                    if (x_over) s_x <= WIDTH_L - s_size;
                    if (y_over) s_y <= HEIGHT_L - s_size;
                end
                ST_MOVE_X: begin
                    if (iEnable) begin
                        s_x   <= ax_pos_next;
                        dir_x <= ax_dir_next;
                    end
                end
                ST_MOVE_Y: begin
                    if (iEnable) begin
                        s_y   <= ax_pos_next;
                        dir_y <= ax_dir_next;
                    end
                end
                ST_COMMIT: begin
                    oShapeX    <= s_x;
                    oShapeY    <= s_y;
                    oShapeSize <= s_size;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_shape_mover.sv
// Purpose: self-checking bench for vga_shape_mover against a plain-arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_shape_mover;

    logic       clk = 1'b0;
    logic       rst, vs, en, up, dn;
    logic [9:0] x1, y1, s1, x2, y2, s2;
    logic       busy1, upd1, busy2, upd2;

    always #5 clk = ~clk;

    // dut: default parameters; dut2: starts near the right edge, updates every 2nd frame
    vga_shape_mover dut (
        .iClk(clk), .iRst(rst), .iVS(vs), .iEnable(en), .iSizeUp(up), .iSizeDown(dn),
        .oShapeX(x1), .oShapeY(y1), .oShapeSize(s1), .oBusy(busy1), .oUpdate(upd1)
    );

    vga_shape_mover #(.INIT_X(578), .FRAME_DIV(2)) dut2 (
        .iClk(clk), .iRst(rst), .iVS(vs), .iEnable(en), .iSizeUp(up), .iSizeDown(dn),
        .oShapeX(x2), .oShapeY(y2), .oShapeSize(s2), .oBusy(busy2), .oUpdate(upd2)
    );

    int chk  = 0;
    int pass = 0;

    typedef struct {
        int x;
        int y;
        int s;
        int dx;   // +1 right, -1 left
        int dy;   // +1 down,  -1 up
    } shp_t;

    shp_t m1, m2;
    int   cnt2;
    int   lat1, nupd1, nupd2, nbusy1, exp_upd2;

    // Geometry after one update, straight from the behavioural rules
    function automatic shp_t model_step(shp_t c, bit e, bit u, bit d);
        shp_t r = c;
        if (u && !d && r.s + 4 <= 200)      r.s = r.s + 4;
        else if (d && !u && r.s - 4 >= 8)   r.s = r.s - 4;
        if (r.x + r.s > 640) r.x = 640 - r.s;
        if (r.y + r.s > 480) r.y = 480 - r.s;
        if (e) begin
            if (r.dx > 0) begin
                if (r.x + 2 + r.s >= 640) begin r.x = 640 - r.s; r.dx = -1; end
                else r.x = r.x + 2;
            end else begin
                if (r.x <= 2) begin r.x = 0; r.dx = 1; end
                else r.x = r.x - 2;
            end
            if (r.dy > 0) begin
                if (r.y + 1 + r.s >= 480) begin r.y = 480 - r.s; r.dy = -1; end
                else r.y = r.y + 1;
            end else begin
                if (r.y <= 1) begin r.y = 0; r.dy = 1; end
                else r.y = r.y - 1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m1   = '{290, 210, 60, 1, 1};
        m2   = '{578, 210, 60, 1, 1};
        cnt2 = 0;
    endtask

    // One vsync frame: falling edge at negedge 0, optional second edge while busy.
    // Samples 14 negedges, then advances the models.
    task automatic do_frame(input bit glitch);
        nupd1 = 0; nupd2 = 0; nbusy1 = 0; lat1 = -1;
        @(negedge clk) vs = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (upd1) begin
                nupd1++;
                if (lat1 < 0) lat1 = i;
            end
            if (busy1) nbusy1++;
            if (upd2)  nupd2++;
            if (i == 2) vs = 1'b1;
            if (glitch && i == 3) vs = 1'b0;
            if (glitch && i == 4) vs = 1'b1;
        end
        m1 = model_step(m1, en, up, dn);
        // The busy-time edge is dropped; dut2 updates exactly once either way
        if (glitch || cnt2 == 1) begin
            m2 = model_step(m2, en, up, dn);
            cnt2 = 0;
            exp_upd2 = 1;
        end else begin
            cnt2 = 1;
            exp_upd2 = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vs = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk++; if (x1 !== 10'd290) $display("FAIL reset_x held: got %0d want 290", x1); else pass++;
        chk++; if (busy1 !== 1'b0) $display("FAIL reset_busy held: got %b want 0", busy1); else pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk++; if (x1 !== 10'd290) $display("FAIL reset_x: got %0d want 290", x1); else pass++;
        chk++; if (y1 !== 10'd210) $display("FAIL reset_y: got %0d want 210", y1); else pass++;
        chk++; if (s1 !== 10'd60)  $display("FAIL reset_size: got %0d want 60", s1); else pass++;
        chk++; if (busy1 !== 1'b0 || upd1 !== 1'b0)
            $display("FAIL reset_flags: got busy=%b upd=%b want 0/0", busy1, upd1); else pass++;
        chk++; if (x2 !== 10'd578) $display("FAIL reset_x2: got %0d want 578", x2); else pass++;
    endtask

    task automatic test_first_update();
        en = 1'b1;
        do_frame(1'b0);
        chk++; if (lat1 !== 5)  $display("FAIL first_latency: got %0d want 5", lat1); else pass++;
        chk++; if (nbusy1 !== 5) $display("FAIL first_busy_cycles: got %0d want 5", nbusy1); else pass++;
        chk++; if (nupd1 !== 1) $display("FAIL first_update_count: got %0d want 1", nupd1); else pass++;
        chk++; if (x1 !== 10'd292) $display("FAIL first_x: got %0d want 292", x1); else pass++;
        chk++; if (y1 !== 10'd211) $display("FAIL first_y: got %0d want 211", y1); else pass++;
        chk++; if (s1 !== 10'd60)  $display("FAIL first_size: got %0d want 60", s1); else pass++;
        chk++; if (nupd2 !== 0 || x2 !== 10'd578)
            $display("FAIL div2_first_edge: got upd=%0d x=%0d want 0/578", nupd2, x2); else pass++;
    endtask

    task automatic test_bounce();
        en = 1'b1;
        do_frame(1'b0);
        chk++; if (nupd2 !== 1) $display("FAIL div2_second_edge: got %0d updates want 1", nupd2); else pass++;
        chk++; if (x2 !== 10'd580) $display("FAIL bounce_right_x: got %0d want 580", x2); else pass++;
        do_frame(1'b0);
        chk++; if (nupd2 !== 0) $display("FAIL div2_odd_edge: got %0d updates want 0", nupd2); else pass++;
        do_frame(1'b0);
        chk++; if (x2 !== 10'd578) $display("FAIL bounce_left_x: got %0d want 578", x2); else pass++;
        chk++; if (x1 !== 10'(m1.x) || y1 !== 10'(m1.y))
            $display("FAIL bounce_dut1_pos: got %0d,%0d want %0d,%0d", x1, y1, m1.x, m1.y); else pass++;
    endtask

    task automatic test_resize();
        en = 1'b0; up = 1'b1; dn = 1'b0;
        do_frame(1'b0);
        do_frame(1'b0);
        chk++; if (s2 !== 10'd64)  $display("FAIL grow_clamp_size: got %0d want 64", s2); else pass++;
        chk++; if (x2 !== 10'd576) $display("FAIL grow_clamp_x: got %0d want 576", x2); else pass++;
        for (int f = 0; f < 40; f++) do_frame(1'b0);
        chk++; if (s1 !== 10'd200) $display("FAIL size_max: got %0d want 200", s1); else pass++;
        chk++; if (s1 !== 10'(m1.s) || x1 !== 10'(m1.x))
            $display("FAIL size_max_model: got %0d,%0d want %0d,%0d", s1, x1, m1.s, m1.x); else pass++;
        dn = 1'b1;
        do_frame(1'b0);
        chk++; if (s1 !== 10'd200) $display("FAIL size_both_req: got %0d want 200", s1); else pass++;
        up = 1'b0;
        for (int f = 0; f < 50; f++) do_frame(1'b0);
        chk++; if (s1 !== 10'd8) $display("FAIL size_min: got %0d want 8", s1); else pass++;
        dn = 1'b0;
    endtask

    task automatic test_back_to_back();
        en = 1'b1;
        do_frame(1'b1);
        chk++; if (nupd1 !== 1) $display("FAIL busy_edge_dut1: got %0d updates want 1", nupd1); else pass++;
        chk++; if (nupd2 !== 1) $display("FAIL busy_edge_dut2: got %0d updates want 1", nupd2); else pass++;
        chk++; if (x1 !== 10'(m1.x) || x2 !== 10'(m2.x))
            $display("FAIL busy_edge_x: got %0d,%0d want %0d,%0d", x1, x2, m1.x, m2.x); else pass++;
    endtask

    task automatic test_random();
        int r;
        bit g;
        for (int f = 0; f < 320; f++) begin
            en = ($urandom_range(0, 9) != 0);
            r  = $urandom_range(0, 7);
            up = (r == 0) || (r == 2);
            dn = (r == 1) || (r == 2);
            g  = ($urandom_range(0, 9) == 0);
            do_frame(g);
            chk++; if (nupd1 !== 1 || nupd2 !== exp_upd2)
                $display("FAIL rand_updates f%0d: got %0d,%0d want 1,%0d", f, nupd1, nupd2, exp_upd2); else pass++;
            chk++; if (x1 !== 10'(m1.x) || y1 !== 10'(m1.y) || s1 !== 10'(m1.s))
                $display("FAIL rand_dut1 f%0d: got %0d,%0d,%0d want %0d,%0d,%0d",
                         f, x1, y1, s1, m1.x, m1.y, m1.s); else pass++;
            chk++; if (x2 !== 10'(m2.x) || y2 !== 10'(m2.y) || s2 !== 10'(m2.s))
                $display("FAIL rand_dut2 f%0d: got %0d,%0d,%0d want %0d,%0d,%0d",
                         f, x2, y2, s2, m2.x, m2.y, m2.s); else pass++;
        end
        up = 1'b0; dn = 1'b0;
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        @(negedge clk) vs = 1'b0;
        @(negedge clk);
        @(negedge clk) vs = 1'b1;
        @(negedge clk);
        chk++; if (busy1 !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy1); else pass++;
        rst = 1'b1;
        #1;
        chk++; if (x1 !== 10'd290 || y1 !== 10'd210 || s1 !== 10'd60)
            $display("FAIL mid_reset_out: got %0d,%0d,%0d want 290,210,60", x1, y1, s1); else pass++;
        chk++; if (busy1 !== 1'b0 || upd1 !== 1'b0)
            $display("FAIL mid_reset_flags: got busy=%b upd=%b want 0/0", busy1, upd1); else pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_frame(1'b0);
        chk++; if (x1 !== 10'd292 || y1 !== 10'd211)
            $display("FAIL post_reset_move: got %0d,%0d want 292,211", x1, y1); else pass++;
    endtask

    initial begin
        test_reset();
        test_first_update();
        test_bounce();
        test_resize();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
